// File: rtl/dp_pkg.sv
// Shared types and constants for the dot-product arbiter: FSM encoding,
// operand geometry, mode encoding and the operand unpacking helper.
package dp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int OPND_W = 128;

   localparam logic MODE_HALF   = 1'b1;
   localparam logic MODE_SINGLE = 1'b0;

   localparam logic [31:0] ERR_RESULT = 32'h0000_0000;

   // Half-precision operands only own the low 16 bits of each 32-bit lane.
   localparam logic [OPND_W-1:0] HALF_MASK = {4{32'h0000_FFFF}};

   // Operand widened to a single-precision-like form: fp32 exponent bias,
   // hidden bit made explicit, zero flagged separately (denormals flush).
   typedef struct packed {
      logic        sign;
      logic        zero;
      logic [7:0]  exp;
      logic [23:0] mant;
   } fp_t;

   function automatic fp_t unpack_operand(input logic [31:0] w, input logic half);
      fp_t f;
      if (half == MODE_HALF) begin
         f.sign = w[15];
         f.zero = (w[14:10] == 5'd0);
         f.exp  = {3'b000, w[14:10]} + 8'd112;
         f.mant = {1'b1, w[9:0], 13'b0};
      end else begin
         f.sign = w[31];
         f.zero = (w[30:23] == 8'd0);
         f.exp  = w[30:23];
         f.mant = {1'b1, w[22:0]};
      end
      return f;
   endfunction

endpackage

// File: rtl/dp_nonpipe.sv
// Combinational four-term floating-point dot product (half or single).
// Products are aligned to the largest exponent, summed exactly, then truncated.
module dp_nonpipe
   import dp_pkg::*;
(
   input  logic [OPND_W-1:0] x,
   input  logic [OPND_W-1:0] y,
   input  logic              half,
   output logic [31:0]       result
);

   localparam int PROD_W = 48;
   localparam int ACC_W  = 52;
   localparam logic signed [11:0] ZERO_EXP = -12'sd1024;

   fp_t                xu [4];
   fp_t                yu [4];
   logic [PROD_W-1:0]  prod_mant [4];
   logic signed [11:0] prod_exp [4];
   logic               prod_sign [4];
   logic signed [11:0] max_exp;
   logic signed [11:0] diff;
   logic [ACC_W-1:0]   aligned;
   logic signed [ACC_W-1:0] acc;
   logic [ACC_W-2:0]   mag;
   logic               res_sign;
   logic [5:0]         lead;
   logic signed [11:0] res_exp;
   logic signed [11:0] half_exp;
   logic [22:0]        res_frac;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         xu[i]        = unpack_operand(x[32*i +: 32], half);
         yu[i]        = unpack_operand(y[32*i +: 32], half);
         prod_sign[i] = xu[i].sign ^ yu[i].sign;
         if (xu[i].zero || yu[i].zero) begin
            prod_mant[i] = '0;
            prod_exp[i]  = ZERO_EXP;
         end else begin
            prod_mant[i] = {24'b0, xu[i].mant} * {24'b0, yu[i].mant};
            prod_exp[i]  = $signed({4'b0, xu[i].exp}) + $signed({4'b0, yu[i].exp}) - 12'sd127;
         end
      end
   end

   // Align every product to the largest exponent and accumulate in two's complement.
   always_comb begin
      max_exp = ZERO_EXP;
      for (int i = 0; i < 4; i++) begin
         if (prod_exp[i] > max_exp) max_exp = prod_exp[i];
      end
      acc     = '0;
      diff    = '0;
      aligned = '0;
      for (int i = 0; i < 4; i++) begin
         diff    = max_exp - prod_exp[i];
         aligned = '0;
         if ((prod_mant[i] != '0) && (diff < 12'sd50)) begin
            aligned = {{(ACC_W-PROD_W){1'b0}}, prod_mant[i]} >> diff[5:0];
         end
         if (prod_sign[i]) acc = acc - $signed(aligned);
         else              acc = acc + $signed(aligned);
      end
   end

   always_comb begin
      res_sign = acc[ACC_W-1];
      mag      = res_sign ? (ACC_W-1)'(-acc) : acc[ACC_W-2:0];
      lead     = '0;
      for (int b = 0; b < ACC_W-1; b++) begin
         if (mag[b]) lead = 6'(b);
      end
      res_exp  = max_exp + $signed({6'b0, lead}) - 12'sd46;
      half_exp = res_exp - 12'sd112;
      res_frac = (lead >= 6'd23) ? 23'(mag >> (lead - 6'd23)) : 23'(mag << (6'd23 - lead));
   end

   // Out-of-range exponents saturate to infinity or flush to zero.
   always_comb begin
      result = '0;
      if (mag != '0) begin
         if (half == MODE_HALF) begin
            if (half_exp <= 12'sd0)       result = '0;
            else if (half_exp >= 12'sd31) result = {16'b0, res_sign, 5'h1F, 10'b0};
            else                          result = {16'b0, res_sign, half_exp[4:0], res_frac[22:13]};
         end else begin
            if (res_exp <= 12'sd0)        result = '0;
            else if (res_exp >= 12'sd255) result = {res_sign, 8'hFF, 23'b0};
            else                          result = {res_sign, res_exp[7:0], res_frac};
         end
      end
   end

endmodule

// File: rtl/dp_arbiter.sv
// Two-requester round-robin front end for a single shared dot-product unit,
// one operation in flight: IDLE accepts, EXEC computes, RESP waits for the owner.
module dp_arbiter
   import dp_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [127:0]     req0_x,
   input  logic [127:0]     req0_y,
   input  logic             req0_half,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [127:0]     req1_x,
   input  logic [127:0]     req1_y,
   input  logic             req1_half,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [31:0]      rsp0_data,
   output logic             rsp0_err,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [31:0]      rsp1_data,
   output logic             rsp1_err,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic [OPND_W-1:0]   x_q, x_d;
   logic [OPND_W-1:0]   y_q, y_d;
   logic                half_q, half_d;
   logic [31:0]         result_q, result_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    ops_done_q, ops_done_d;

   logic                grant_valid;
   logic                grant_id;
   logic                rsp_fire;
   logic                mode_conflict;
   logic [31:0]         dp_result;

   dp_nonpipe u_dp (
      .x      (x_q),
      .y      (y_q),
      .half   (half_q),
      .result (dp_result)
   );

   // Requester 0 wins ties when requester 1 was granted last, and vice versa.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) grant_id = ~last_grant_q;
      else if (req1_valid)          grant_id = 1'b1;
      grant_valid   = (state_q == ST_IDLE) && (req0_valid || req1_valid) && !rst;
      rsp_fire      = (state_q == ST_RESP) && (owner_q ? rsp1_ready : rsp0_ready);
      mode_conflict = (half_q == MODE_SINGLE) && (x_q[31:16] == 16'h0000);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (grant_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: if (rsp_fire) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = grant_valid && !grant_id;
      req1_ready = grant_valid && grant_id;
      rsp0_valid = (state_q == ST_RESP) && !owner_q;
      rsp1_valid = (state_q == ST_RESP) && owner_q;
      rsp0_data  = result_q;
      rsp1_data  = result_q;
      rsp0_err   = rsp0_valid && err_q;
      rsp1_err   = rsp1_valid && err_q;
      busy       = (state_q != ST_IDLE);
      ops_done   = ops_done_q;
   end

   always_comb begin
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      x_d          = x_q;
      y_d          = y_q;
      half_d       = half_q;
      result_d     = result_q;
      err_d        = err_q;
      ops_done_d   = ops_done_q;
      if (grant_valid) begin
         last_grant_d = grant_id;
         owner_d      = grant_id;
         half_d       = grant_id ? req1_half : req0_half;
         x_d          = grant_id ? req1_x : req0_x;
         y_d          = grant_id ? req1_y : req0_y;
         if (half_d == MODE_HALF) begin
            x_d = x_d & HALF_MASK;
            y_d = y_d & HALF_MASK;
         end
      end
      if (state_q == ST_EXEC) begin
         result_d = mode_conflict ? ERR_RESULT : dp_result;
         err_d    = mode_conflict;
      end
      if (rsp_fire) ops_done_d = ops_done_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         half_q       <= 1'b0;
         result_q     <= '0;
         err_q        <= 1'b0;
         ops_done_q   <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         x_q          <= x_d;
         y_q          <= y_d;
         half_q       <= half_d;
         result_q     <= result_d;
         err_q        <= err_d;
         ops_done_q   <= ops_done_d;
      end
   end

endmodule

// File: doc/dp_arbiter.md
DP_ARBITER -- requirements
Module: dp_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 SHALL have ports reqN_ready  output  1  requester N's operation is accepted this cycle.
REQ-006 SHALL have ports reqN_x  input  128  operands x1..x4, with x1 in bits [31:0] and x4 in [127:96].
REQ-007 SHALL have ports reqN_y  input  128  operands y1..y4, same packing as reqN_x.
REQ-008 SHALL have ports reqN_half  input  1  1 = half-precision operation, 0 = single-precision operation.
REQ-009 SHALL have ports rspN_valid  output  1  result for requester N is available.
REQ-010 SHALL have ports rspN_ready  input  1  requester N consumes the result.
REQ-011 SHALL have ports rspN_data  output  32  packed dot-product result.
REQ-012 SHALL have ports rspN_err  output  1  the operation was rejected for a mode conflict.
REQ-013 SHALL have port busy  output  1  the FSM is not in IDLE.
REQ-014 SHALL have port ops_done  output  CNT_W  count of completed responses.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC and RESP, with exactly one operation outstanding.
REQ-016 In IDLE, with at least one reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally, capture x/y/half/owner into operand registers, and go to EXEC.
REQ-017 SHALL assert reqN_ready only in IDLE and only for the granted requester; both ready outputs SHALL never be high together.
REQ-018 Arbitration SHALL be round-robin: if both requesters are valid, grant the one not in last_grant; if one is valid, grant it; update last_grant on every grant.
REQ-019 In half mode, SHALL force bits [31:16] of all eight captured operands to zero before they reach the datapath.
REQ-020 In single mode, if captured x1[31:16]==0, SHALL set err, drive result 0x00000000 and not use the datapath output.
REQ-021 In EXEC, SHALL register the combinational datapath result (or the err result) into the result register, then go to RESP.
REQ-022 In RESP, SHALL assert rspN_valid for the owner only, holding rspN_data and rspN_err stable until rspN_ready.
REQ-023 In RESP with rspN_ready=1, SHALL increment ops_done (wrapping at 2^CNT_W) and return to IDLE.
REQ-024 Latency SHALL be exactly 2 cycles from the accept edge to rspN_valid; with ready held high, throughput SHALL be one operation per 3 cycles.
REQ-025 SHALL ignore rspN_ready from the non-owner and reqN_valid in EXEC/RESP; requesters SHALL hold their request until ready.
REQ-026 Per requester, rspN_valid rising order SHALL follow that requester's accept order (trivially satisfied by a single outstanding operation).
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 On rst, SHALL set state=IDLE, last_grant=1 (so requester 0 wins first), ops_done=0, operand and result registers to 0, and all valid, ready and err outputs to 0.
REQ-029 Reset asserted in EXEC or RESP SHALL abandon the operation with no response issued and no counter increment.

Structure
REQ-030 SHALL place the state encoding, the 128-bit operand width, the error result constant and the mode encoding (half=1, single=0) in the shared package dp_pkg.
REQ-031 SHALL instantiate the combinational four-term dot-product datapath as the single sub-module dp_nonpipe, fed from the operand registers.

Verification
REQ-032 Single accept: req0 half, all x/y=0x3C00 (1.0) -> rsp0_valid 2 cycles after accept, rsp0_data=0x00004400, err=0, ops_done=1.
REQ-033 Contention: both requesters valid continuously out of reset -> grants alternate 0,1,0,1 and each rsp reaches only its owner.
REQ-034 Backpressure: rsp1_ready held low 10 cycles -> rsp1_valid/data stable, busy=1, req0 not accepted until the rsp1 handshake completes.
REQ-035 Mode conflict: single mode with x1=0x00001234 -> rsp_err=1, rsp_data=0, and the counter still increments.
REQ-036 Reset mid-op: rst in EXEC -> next cycle IDLE, no rsp_valid, ops_done unchanged at 0, and req0 wins the next grant.
REQ-037 Wrap: CNT_W=4 with 17 completions -> ops_done=1.
